// File: rtl/neurex_pkg.sv
// Shared types and derived sizes for the accumulator-to-output activation path.
package neurex_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned accum_row(input int unsigned accum_size,
                                              input int unsigned sys_col);
        return accum_size / sys_col;
    endfunction

endpackage

// File: rtl/act_unit.sv
// Per-lane activation: optional ReLU, arithmetic right shift, saturation to DATA_WIDTH.
module act_unit #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic signed [2*DATA_WIDTH-1:0] psum,
    input  logic                           relu_en,
    input  logic        [4:0]              shift,
    output logic        [DATA_WIDTH-1:0]   result
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] shifted;
    logic signed [PW-1:0] max_v;
    logic signed [PW-1:0] min_v;

    always_comb begin
        max_v   = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
        min_v   = ~max_v;
        shifted = psum >>> shift;
        if (relu_en && psum[PW-1]) begin
            result = '0;
        end else if (shifted > max_v) begin
            result = max_v[DATA_WIDTH-1:0];
        end else if (shifted < min_v) begin
            result = min_v[DATA_WIDTH-1:0];
        end else begin
            result = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/relu_out_ctrl.sv
// Streams num_row accumulator rows through per-lane activation into output memory.
module relu_out_ctrl
    import neurex_pkg::*;
#(
    parameter int unsigned SYS_COL    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ACCUM_SIZE = 1024,
    localparam int unsigned ACCUM_ROW = accum_row(ACCUM_SIZE, SYS_COL),
    localparam int unsigned ACCUM_AW  = $clog2(ACCUM_ROW)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      relu_en,
    input  logic [4:0]                shift,
    input  logic [DATA_WIDTH-1:0]     num_row,
    input  logic [ACCUM_AW-1:0]       accum_base,
    input  logic [ADDR_WIDTH-1:0]     out_base,
    output logic [SYS_COL-1:0]        accum_rd_en,
    output logic [ACCUM_AW-1:0]       accum_rd_addr [SYS_COL],
    input  logic [2*DATA_WIDTH-1:0]   accum_rd_data [SYS_COL],
    output logic [SYS_COL-1:0]        out_wr_en,
    output logic [ADDR_WIDTH-1:0]     out_wr_addr [SYS_COL],
    output logic [DATA_WIDTH-1:0]     out_wr_data [SYS_COL],
    output logic                      busy,
    output logic                      done
);

    state_e state_q, state_d;

    logic                  relu_q;
    logic [4:0]            shift_q;
    logic [DATA_WIDTH-1:0] num_q;
    logic [ACCUM_AW-1:0]   abase_q;
    logic [ADDR_WIDTH-1:0] obase_q;
    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] last_k;
    logic                  accept;
    logic                  reading;

    // Stage 1: read data returning; stage 2: registered write to output memory.
    logic                  rd_v_q;
    logic [ADDR_WIDTH-1:0] k1_q;
    logic                  wr_v_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q [SYS_COL];
    logic [DATA_WIDTH-1:0] act_res   [SYS_COL];

    assign last_k  = num_q - DATA_WIDTH'(1);
    assign reading = (state_q == StRead);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    accept  = 1'b1;
                    state_d = (num_row == '0) ? StDrain : StRead;
                end
            end
            StRead:  if (cnt_q == last_k) state_d = StDrain;
            StDrain: if (!rd_v_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            relu_q    <= 1'b0;
            shift_q   <= '0;
            num_q     <= '0;
            abase_q   <= '0;
            obase_q   <= '0;
            cnt_q     <= '0;
            rd_v_q    <= 1'b0;
            k1_q      <= '0;
            wr_v_q    <= 1'b0;
            wr_addr_q <= '0;
            for (int l = 0; l < SYS_COL; l++) wr_data_q[l] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                relu_q  <= relu_en;
                shift_q <= shift;
                num_q   <= num_row;
                abase_q <= accum_base;
                obase_q <= out_base;
                cnt_q   <= '0;
            end else if (reading) begin
                cnt_q <= cnt_q + DATA_WIDTH'(1);
            end
            rd_v_q    <= reading;
            k1_q      <= cnt_q[ADDR_WIDTH-1:0];
            wr_v_q    <= rd_v_q;
            wr_addr_q <= rd_v_q ? obase_q + k1_q : '0;
            for (int l = 0; l < SYS_COL; l++) wr_data_q[l] <= rd_v_q ? act_res[l] : '0;
        end
    end

    for (genvar g = 0; g < SYS_COL; g++) begin : g_lane
        act_unit #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_act (
            .psum    (accum_rd_data[g]),
            .relu_en (relu_q),
            .shift   (shift_q),
            .result  (act_res[g])
        );
    end

    always_comb begin
        accum_rd_en = {SYS_COL{reading}};
        out_wr_en   = {SYS_COL{wr_v_q}};
        for (int l = 0; l < SYS_COL; l++) begin
            accum_rd_addr[l] = reading ? abase_q + cnt_q[ACCUM_AW-1:0] : '0;
            out_wr_addr[l]   = wr_addr_q;
            out_wr_data[l]   = wr_data_q[l];
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_relu_out_ctrl.sv
// Randomized bench for relu_out_ctrl with an accumulator memory and a schedule-based model.
module tb_relu_out_ctrl;

    localparam int SC  = 4;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int AAW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           relu_en;
    logic [4:0]     shift;
    logic [DW-1:0]  num_row;
    logic [AAW-1:0] accum_base;
    logic [AW-1:0]  out_base;
    logic [SC-1:0]  accum_rd_en;
    logic [AAW-1:0] accum_rd_addr [SC];
    logic [2*DW-1:0] accum_rd_data [SC];
    logic [SC-1:0]  out_wr_en;
    logic [AW-1:0]  out_wr_addr [SC];
    logic [DW-1:0]  out_wr_data [SC];
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [SC][256];

    relu_out_ctrl #(
        .SYS_COL    (SC),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ACCUM_SIZE (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .relu_en       (relu_en),
        .shift         (shift),
        .num_row       (num_row),
        .accum_base    (accum_base),
        .out_base      (out_base),
        .accum_rd_en   (accum_rd_en),
        .accum_rd_addr (accum_rd_addr),
        .accum_rd_data (accum_rd_data),
        .out_wr_en     (out_wr_en),
        .out_wr_addr   (out_wr_addr),
        .out_wr_data   (out_wr_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Accumulator memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        for (int l = 0; l < SC; l++)
            accum_rd_data[l] <= accum_rd_en[l] ? mem[l][accum_rd_addr[l]] : $urandom;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_act(input logic [31:0] psum, input bit relu,
                                            input int sh);
        longint v;
        v = longint'($signed(psum));
        if (relu && v < 0) return 16'h0;
        v = v >>> sh;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, accum_rd_en, 0);
        check_eq({tag, "_wr_en"}, out_wr_en, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        for (int l = 0; l < SC; l++) begin
            check_eq($sformatf("%s_rd_addr%0d", tag, l), accum_rd_addr[l], 0);
            check_eq($sformatf("%s_wr_addr%0d", tag, l), out_wr_addr[l], 0);
            check_eq($sformatf("%s_wr_data%0d", tag, l), out_wr_data[l], 0);
        end
    endtask

    task automatic randomize_mem();
        for (int l = 0; l < SC; l++)
            for (int r = 0; r < 256; r++) mem[l][r] = $urandom;
    endtask

    // Cycle n counts from the cycle after en is accepted. Reads at n=1..N,
    // writes at n=3..N+2, done at N+3 (or at n=2 when N=0).
    task automatic run_xfer(input int n_rows, input int ab, input int ob, input int sh,
                            input bit relu, input bit noise, input int rst_at);
        int  n_done;
        bit  rd;
        bit  wr;
        int  k;
        n_done = (n_rows == 0) ? 2 : n_rows + 3;
        @(negedge clk);
        en         = 1'b1;
        relu_en    = relu;
        shift      = 5'(sh);
        num_row    = DW'(n_rows);
        accum_base = AAW'(ab);
        out_base   = AW'(ob);
        for (int n = 1; n <= n_done; n++) begin
            @(negedge clk);
            rd = (n <= n_rows);
            wr = (n >= 3) && (n <= n_rows + 2);
            check_eq($sformatf("rd_en n=%0d", n), accum_rd_en, {SC{rd}});
            if (rd)
                for (int l = 0; l < SC; l++)
                    check_eq($sformatf("rd_addr%0d n=%0d", l, n), accum_rd_addr[l],
                             (ab + n - 1) % 256);
            check_eq($sformatf("wr_en n=%0d", n), out_wr_en, {SC{wr}});
            if (wr) begin
                k = n - 3;
                for (int l = 0; l < SC; l++) begin
                    check_eq($sformatf("wr_addr%0d k=%0d", l, k), out_wr_addr[l], (ob + k) % 256);
                    check_eq($sformatf("wr_data%0d k=%0d", l, k), out_wr_data[l],
                             ref_act(mem[l][(ab + k) % 256], relu, sh));
                end
            end
            check_eq($sformatf("done n=%0d", n), done, n == n_done);
            if (n < n_done) check_eq($sformatf("busy n=%0d", n), busy, 1);
            if (n == rst_at) begin
                en  = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check_all_zero("midrst");
                rst = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    check_eq("post_rst_wr_en", out_wr_en, 0);
                    check_eq("post_rst_rd_en", accum_rd_en, 0);
                    check_eq("post_rst_done", done, 0);
                end
                return;
            end
            if (noise && n < n_done) begin
                en         = $urandom_range(0, 1);
                relu_en    = $urandom_range(0, 1);
                shift      = 5'($urandom);
                num_row    = DW'($urandom);
                accum_base = AAW'($urandom);
                out_base   = AW'($urandom);
            end else begin
                en = 1'b0;
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        relu_en    = 1'b0;
        shift      = '0;
        num_row    = '0;
        accum_base = '0;
        out_base   = '0;
        randomize_mem();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Basic pass-through, psums 1..16
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < SC; l++) mem[l][r] = 32'(r * SC + l + 1);
        run_xfer(4, 0, 'h10, 0, 0, 0, 0);

        // ReLU clamps negatives
        mem[1][20] = -32'sd5;
        mem[2][20] = 32'd7;
        run_xfer(1, 20, 'h30, 0, 1, 0, 0);

        // Shift and saturation corners
        mem[0][30] = 32'h0003_0000;
        run_xfer(1, 30, 0, 4, 0, 0, 0);
        mem[0][31] = 32'h7FFF_FFFF;
        mem[1][31] = 32'h8000_0000;
        run_xfer(1, 31, 0, 0, 0, 0, 0);

        // Address wrap on both sides
        run_xfer(4, 254, 'hFE, 0, 0, 0, 0);

        // Empty transfer with en re-pulsed while busy
        run_xfer(0, 5, 5, 0, 0, 1, 0);

        // Reset in the third read cycle, then a clean run
        run_xfer(6, 10, 'h40, 2, 1, 0, 3);
        run_xfer(5, 10, 'h40, 2, 1, 0, 0);

        for (int t = 0; t < 25; t++) begin
            randomize_mem();
            run_xfer($urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0);
        end

        @(negedge clk);
        check_eq("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/relu_out_ctrl.md
RELU_OUT_CTRL -- requirements
Module: relu_out_ctrl

Interface
REQ-001 SHALL have parameter SYS_COL, default 4: number of accumulator/output lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: output word width; psum width is 2*DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: output memory address width.
REQ-004 SHALL have parameter ACCUM_SIZE, default 1024: derived ACCUM_ROW = ACCUM_SIZE/SYS_COL (accum address width = clog2(ACCUM_ROW)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1: start pulse.
REQ-008 SHALL have port relu_en, input, 1: when high, negative values become 0.
REQ-009 SHALL have port shift, input, 5: arithmetic right-shift amount.
REQ-010 SHALL have port num_row, input, DATA_WIDTH: rows to transfer.
REQ-011 SHALL have port accum_base, input, clog2(ACCUM_ROW): first accumulator row.
REQ-012 SHALL have port out_base, input, ADDR_WIDTH: first output memory row.
REQ-013 SHALL have port accum_rd_en, output, SYS_COL: per-lane accumulator read enable.
REQ-014 SHALL have port accum_rd_addr, output, clog2(ACCUM_ROW) x SYS_COL unpacked: per-lane read row.
REQ-015 SHALL have port accum_rd_data, input, 2*DATA_WIDTH x SYS_COL unpacked: signed psum, valid 1 cycle after read.
REQ-016 SHALL have port out_wr_en, output, SYS_COL: per-lane output memory write enable.
REQ-017 SHALL have port out_wr_addr, output, ADDR_WIDTH x SYS_COL unpacked: per-lane write row.
REQ-018 SHALL have port out_wr_data, output, DATA_WIDTH x SYS_COL unpacked: per-lane activated result.
REQ-019 SHALL have port busy, output, 1: high from the cycle after accepted en until done.
REQ-020 SHALL have port done, output, 1: single-cycle pulse after the last write.

Function
REQ-021 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-022 SHALL accept en only in IDLE, latching relu_en, shift, num_row, accum_base and out_base; en outside IDLE is ignored.
REQ-023 In READ, SHALL issue one row per cycle on all lanes (accum_rd_en all ones, addr = accum_base+k) for k = 0..num_row-1.
REQ-024 Pipeline: read at cycle t, data at t+1, registered activation; out_wr_en/addr/data at t+2 with addr = out_base+k.
REQ-025 Activation per lane: if relu_en and psum<0 then 0; else psum >>> shift (signed), then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 DRAIN SHALL last until the final write has issued; DONE asserts done for exactly one cycle, then returns to IDLE.
REQ-027 num_row = 0: no reads or writes; done pulses on the second cycle after en.
REQ-028 Accumulator and output addresses SHALL wrap modulo their range (no error).
REQ-029 Total latency en -> done = num_row + 3 cycles for num_row > 0; a new en is accepted the cycle after done.

Reset
REQ-030 rst SHALL force IDLE, clear the pipeline, and drive every output enable, busy, done, addr and data to 0, including when asserted mid-transfer (no further writes).

Structure
REQ-031 ACCUM_ROW derivation and the state enum SHALL live in the shared package neurex_pkg.
REQ-032 The per-lane ReLU/shift/saturate SHALL be the combinational sub-module act_unit, instantiated SYS_COL times.

Verification
REQ-033 num_row=4, accum_base=0, out_base=0x10, shift=0, relu_en=0, psums 1..16 -> writes at 0x10..0x13 equal to the psums; done at en+7.
REQ-034 relu_en=1, psum -5 on lane 1 and 7 on lane 2 -> out_wr_data 0 and 7.
REQ-035 psum 0x0003_0000, shift=4 -> 0x3000; psum 0x7FFF_FFFF, shift=0 -> 0x7FFF; psum 0x8000_0000, relu_en=0 -> 0x8000.
REQ-036 accum_base=254, num_row=4 -> read rows 254, 255, 0, 1; out_base=0xFE -> writes 0xFE, 0xFF, 0x00, 0x01.
REQ-037 num_row=0 -> no enables; done 2 cycles after en; en re-pulsed while busy -> ignored.
REQ-038 rst asserted at the third READ cycle -> all outputs 0 on the next cycle; no later writes; a fresh en then runs normally.
